// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 16x-oversampling asynchronous serial receiver.
//   - Synchronises rx, detects the start bit and samples each bit mid-period.
//   - Checks parity and the stop bit.
//   - Hands the character to the host through a single-entry holding register.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN
//   - Defined: 2-of-3 vote over the samples at cnt 7/8/9; decisions are made on cnt 9.
//   - Undefined: a single sample at cnt 8.
module uart_rx_sampler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [3:0] DECIDE_CNT = 4'd9;
`else
    localparam logic [3:0] DECIDE_CNT = 4'd8;
`endif

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_last;
    logic [3:0]             r_cnt;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic                   r_perr;
    logic [7:0]             r_rx_data;
    logic                   r_data_ready;
    logic                   r_parity_err;
    logic                   r_framing_err;
    logic                   r_overflow;

    logic                   w_rx_s;
    logic                   w_bit;
    logic                   w_decide;
    logic                   w_wrap;
    logic [2:0]             w_last_bit;
    logic [7:0]             w_char;
    logic                   w_start_det;
    logic                   w_shift_en;
    logic                   w_bitcnt_clr;
    logic                   w_bitcnt_inc;
    logic                   w_perr_en;
    logic                   w_deliver;

    assign w_rx_s     = r_sync[SYNC_STAGES-1];
    assign w_decide   = baud_clock && (r_cnt == DECIDE_CNT);
    assign w_wrap     = baud_clock && (r_cnt == 4'd15);
    assign w_last_bit = bit8 ? 3'd7 : 3'd6;
    // In 7-bit mode only seven shifts happen, so the character sits in [7:1].
    assign w_char     = bit8 ? r_shift : {1'b0, r_shift[7:1]};

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_s7;
    logic r_s8;

    // Capture the two early votes; the third is the live sample on cnt 9.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s7 <= 1'b1;
            r_s8 <= 1'b1;
        end else if (baud_clock) begin
            if (r_cnt == 4'd7) r_s7 <= w_rx_s;
            if (r_cnt == 4'd8) r_s8 <= w_rx_s;
        end
    end

    assign w_bit = (r_s7 & r_s8) | (r_s7 & w_rx_s) | (r_s8 & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    // rx synchroniser chain, idle high.
    always_ff @(posedge clk) begin
        if (reset) r_sync <= '1;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end

    // FSM state register, advanced only on baud ticks.
    always_ff @(posedge clk) begin
        if (reset)           r_state <= S_IDLE;
        else if (baud_clock) r_state <= w_state_nxt;
    end

    // Next-state and per-tick datapath controls.
    always_comb begin
        w_state_nxt  = r_state;
        w_start_det  = 1'b0;
        w_shift_en   = 1'b0;
        w_bitcnt_clr = 1'b0;
        w_bitcnt_inc = 1'b0;
        w_perr_en    = 1'b0;
        w_deliver    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Only a real falling edge starts a frame; a held-low line does not.
                if (baud_clock && r_rx_last && !w_rx_s) begin
                    w_start_det = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_decide && w_bit) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wrap) begin
                    w_bitcnt_clr = 1'b1;
                    w_state_nxt  = S_DATA;
                end
            end
            S_DATA: begin
                if (w_decide) w_shift_en = 1'b1;
                if (w_wrap) begin
                    if (r_bitcnt == w_last_bit)
                        w_state_nxt = parity_en ? S_PARITY : S_STOP;
                    else
                        w_bitcnt_inc = 1'b1;
                end
            end
            S_PARITY: begin
                if (w_decide) w_perr_en = 1'b1;
                if (w_wrap)   w_state_nxt = S_STOP;
            end
            S_STOP: begin
                // Return to IDLE half a bit early so the next start edge is caught.
                if (w_decide) begin
                    w_deliver   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tick counter, bit counter, shift register and parity result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_last <= 1'b1;
            r_cnt     <= 4'd0;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'h00;
            r_perr    <= 1'b0;
        end else if (baud_clock) begin
            r_rx_last <= w_rx_s;
            if (w_start_det) r_cnt <= 4'd0;
            else             r_cnt <= r_cnt + 4'd1;
            if (w_bitcnt_clr)      r_bitcnt <= 3'd0;
            else if (w_bitcnt_inc) r_bitcnt <= r_bitcnt + 3'd1;
            if (w_shift_en) r_shift <= {w_bit, r_shift[7:1]};
            if (w_start_det)    r_perr <= 1'b0;
            else if (w_perr_en) r_perr <= ((^w_char) ^ w_bit) != odd_n_even;
        end
    end

    // Holding register and host handshake, evaluated every clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_data     <= 8'h00;
            r_data_ready  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_framing_err <= w_deliver && !w_bit;
            if (w_deliver) begin
                if (!r_data_ready || read_rx_byte) begin
                    r_rx_data    <= w_char;
                    r_parity_err <= parity_en && r_perr;
                    r_data_ready <= 1'b1;
                    r_overflow   <= 1'b0;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (read_rx_byte && r_data_ready) begin
                r_data_ready <= 1'b0;
                r_overflow   <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign data_ready  = r_data_ready;
    assign parity_err  = r_parity_err;
    assign framing_err = r_framing_err;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: baud tick every 4 clk, 64 clk per bit.
module tb_uart_rx_sampler;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_clock = 1'b0;
    logic       rx;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       read_rx_byte;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;

    logic [1:0] div = 2'd0;
    int         ferr_cnt = 0;
    int         ferr_base;
    int         n_total = 0;
    int         n_pass = 0;

    uart_rx_sampler #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .read_rx_byte(read_rx_byte), .rx_data(rx_data), .data_ready(data_ready),
        .parity_err(parity_err), .framing_err(framing_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div        <= div + 2'd1;
        baud_clock <= (div == 2'd3);
    end

    always @(negedge clk) if (framing_err) ferr_cnt <= ferr_cnt + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit period; optional one-tick inverted glitch near the middle.
    task automatic put_bit(input logic v, input logic g);
        rx = v;
        if (g) begin
            wait_clk(32); rx = ~v; wait_clk(4); rx = v; wait_clk(28);
        end else begin
            wait_clk(64);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic b8, input logic pe,
                              input logic pbit, input logic stopbit, input logic g);
        rx = 1'b1;
        wait_clk(32);
        put_bit(1'b0, g);
        for (int i = 0; i < (b8 ? 8 : 7); i++) put_bit(d[i], g);
        if (pe) put_bit(pbit, g);
        put_bit(stopbit, 1'b0);
    endtask

    task automatic do_read();
        @(negedge clk) read_rx_byte = 1'b1;
        @(negedge clk) read_rx_byte = 1'b0;
        wait_clk(1);
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1; bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        read_rx_byte = 1'b0;
        wait_clk(10);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_data_ready", {7'd0, data_ready}, 8'd0);
        check("rst_parity_err", {7'd0, parity_err}, 8'd0);
        check("rst_framing_err", {7'd0, framing_err}, 8'd0);
        check("rst_overflow", {7'd0, overflow}, 8'd0);
        reset = 1'b0;
        wait_clk(40);

        // 8N1, 0xA5
        ferr_base = ferr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("a5_ready", {7'd0, data_ready}, 8'd1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_perr", {7'd0, parity_err}, 8'd0);
        check("a5_ferr_pulses", 8'(ferr_cnt - ferr_base), 8'd0);
        do_read();
        check("a5_read_ready", {7'd0, data_ready}, 8'd0);

        // 7E1, 0x41 with wrong parity bit 1
        bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
        send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("e41_ready", {7'd0, data_ready}, 8'd1);
        check("e41_data", rx_data, 8'h41);
        check("e41_perr", {7'd0, parity_err}, 8'd1);
        do_read();
        // 7O1, 0x41 with parity bit 1 is correct
        odd_n_even = 1'b1;
        send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("o41_data", rx_data, 8'h41);
        check("o41_perr", {7'd0, parity_err}, 8'd0);
        do_read();

        // Short low pulse: rejected at the start-bit check
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        rx = 1'b0; wait_clk(12); rx = 1'b1; wait_clk(200);
        check("glitch_no_ready", {7'd0, data_ready}, 8'd0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("3c_ready", {7'd0, data_ready}, 8'd1);
        check("3c_data", rx_data, 8'h3C);
        do_read();

        // Overflow: second character dropped
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovf_data", rx_data, 8'h11);
        check("ovf_flag", {7'd0, overflow}, 8'd1);
        check("ovf_ready", {7'd0, data_ready}, 8'd1);
        do_read();
        check("ovf_read_ready", {7'd0, data_ready}, 8'd0);
        check("ovf_read_flag", {7'd0, overflow}, 8'd0);

        // Framing error on 0x7E, then line held low
        ferr_base = ferr_cnt;
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fe_pulses", 8'(ferr_cnt - ferr_base), 8'd1);
        check("fe_data", rx_data, 8'h7E);
        check("fe_ready", {7'd0, data_ready}, 8'd1);
        do_read();
        rx = 1'b0; wait_clk(400);
        check("break_no_ready", {7'd0, data_ready}, 8'd0);
        check("break_no_more_ferr", 8'(ferr_cnt - ferr_base), 8'd1);
        rx = 1'b1; wait_clk(64);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("5a_data", rx_data, 8'h5A);
        check("5a_ready", {7'd0, data_ready}, 8'd1);

        // Reset in the middle of the data bits of 0xFF
        rx = 1'b1; wait_clk(32);
        rx = 1'b0; wait_clk(64);
        rx = 1'b1; wait_clk(192);
        @(negedge clk) reset = 1'b1;
        wait_clk(4);
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_ready", {7'd0, data_ready}, 8'd0);
        check("mid_rst_ovf", {7'd0, overflow}, 8'd0);
        check("mid_rst_perr", {7'd0, parity_err}, 8'd0);
        reset = 1'b0;
        wait_clk(64 * 6);
        check("post_rst_idle", {7'd0, data_ready}, 8'd0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("81_data", rx_data, 8'h81);
        do_read();

`ifdef UART_RX_MAJORITY_VOTE_EN
        // One-tick glitch mid-bit is outvoted
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("mv55_data", rx_data, 8'h55);
        check("mv55_ready", {7'd0, data_ready}, 8'd1);
        do_read();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
